// File: rtl/hpio_tx_bringup_ctrl.sv
// HPIO TX native-I/O bring-up sequencer: port reset, VTC enable, per-step timeouts and bounded retries.
// Optional HPIO_CTRL_LOCK_MONITOR_EN: loss of PLL lock in RUN re-enters bring-up under the retry rule.
module hpio_tx_bringup_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned SETTLE_CYCLES  = 13,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pll0_locked,
  input  logic       rst_seq_done,
  input  logic       dly_rdy,
  input  logic       vtc_rdy,
  output logic       hpio_rst,
  output logic       en_vtc,
  output logic       source_rst,
  output logic       link_up,
  output logic       fail,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  localparam int unsigned SYNC_W  = 4;
  localparam int unsigned RETRY_W = 2;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RST_HOLD  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_WAIT_SEQ  = 3'd3,
    ST_WAIT_VTC  = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAIL      = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [SYNC_W-1:0]    sync1_q, sync2_q;
  logic                 hpio_rst_q, en_vtc_q, source_rst_q, link_up_q, fail_q;
  logic                 hpio_rst_d, en_vtc_d, source_rst_d, link_up_d, fail_d;
  logic                 lock_s, seq_s, dly_s, vtc_s;
  logic                 timeout, retry_path, start_acc;

  // Two-flop synchronizers for the asynchronous status inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {pll0_locked, rst_seq_done, dly_rdy, vtc_rdy};
      sync2_q <= sync1_q;
    end
  end

  assign lock_s  = sync2_q[3];
  assign seq_s   = sync2_q[2];
  assign dly_s   = sync2_q[1];
  assign vtc_s   = sync2_q[0];
  assign timeout = (timer_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      hpio_rst_q   <= 1'b1;
      en_vtc_q     <= 1'b0;
      source_rst_q <= 1'b1;
      link_up_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      hpio_rst_q   <= hpio_rst_d;
      en_vtc_q     <= en_vtc_d;
      source_rst_q <= source_rst_d;
      link_up_q    <= link_up_d;
      fail_q       <= fail_d;
    end
  end

  // Next state; ready conditions are tested before the timeout so they win a tie
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    retry_path = 1'b0;
    start_acc  = 1'b0;
    timer_d    = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_RST_HOLD;
        end
      end
      ST_RST_HOLD: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)       state_d    = ST_WAIT_SEQ;
        else if (timeout) retry_path = 1'b1;
      end
      ST_WAIT_SEQ: begin
        if (!lock_s)              retry_path = 1'b1;
        else if (seq_s && dly_s)  state_d    = ST_WAIT_VTC;
        else if (timeout)         retry_path = 1'b1;
      end
      ST_WAIT_VTC: begin
        if (!lock_s)      retry_path = 1'b1;
        else if (vtc_s)   state_d    = ST_SETTLE;
        else if (timeout) retry_path = 1'b1;
      end
      ST_SETTLE: begin
        if (!lock_s)                      retry_path = 1'b1;
        else if (timer_q == SETTLE_LAST)  state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_RST_HOLD;
        end
`ifdef HPIO_CTRL_LOCK_MONITOR_EN
        else if (!lock_s) begin
          retry_path = 1'b1;
        end
`endif
      end
      ST_FAIL: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_RST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (retry_path) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = ST_RST_HOLD;
      end else begin
        state_d = ST_FAIL;
      end
    end

    if (start_acc)          retry_d = '0;
    if (state_d != state_q) timer_d = '0;
  end

  // Outputs are decoded from the next state so they change in the same cycle as the state register
  always_comb begin
    hpio_rst_d   = state_d inside {ST_IDLE, ST_RST_HOLD, ST_FAIL};
    en_vtc_d     = state_d inside {ST_WAIT_VTC, ST_SETTLE, ST_RUN};
    source_rst_d = (state_d != ST_RUN);
    link_up_d    = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  assign hpio_rst   = hpio_rst_q;
  assign en_vtc     = en_vtc_q;
  assign source_rst = source_rst_q;
  assign link_up    = link_up_q;
  assign fail       = fail_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;

endmodule

// File: doc/hpio_tx_bringup_ctrl.md
# hpio_tx_bringup_ctrl

Bring-up sequencer for the HPIO TX native-I/O port. It drives the port reset and `en_vtc_bsc4`, and waits on PLL lock, `rst_seq_done`, `dly_rdy_bsc4` and `vtc_rdy_bsc4` with per-step timeouts and bounded retries. It releases the fabric data-source reset only once the port is ready. It sits between top-level control and the HPIO TX instance, clocked on the RIU clock, and replaces the hand-timed reset/enable sequence used in simulation.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles the port reset is held asserted per attempt.
- `TIMEOUT_CYCLES`, 4096: maximum cycles allowed in each wait state.
- `SETTLE_CYCLES`, 13: cycles between `vtc_rdy` and the source-reset release.
- `MAX_RETRY`, 3: attempts allowed after the first before entering FAIL.
- `CNT_W`, 16: timer width; must hold max(`RST_CYCLES`, `TIMEOUT_CYCLES`, `SETTLE_CYCLES`).

Ports:
- `clk` in 1: RIU clock, 200 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle pulse that begins or restarts bring-up.
- `pll0_locked` in 1: asynchronous; synchronized internally.
- `rst_seq_done` in 1: asynchronous; synchronized internally.
- `dly_rdy` in 1: asynchronous; synchronized internally.
- `vtc_rdy` in 1: asynchronous; synchronized internally.
- `hpio_rst` out 1: active-high reset to the HPIO TX port.
- `en_vtc` out 1: enable to the port's VTC input.
- `source_rst` out 1: active-high reset to the data source.
- `link_up` out 1: high in RUN.
- `fail` out 1: high in FAIL.
- `state` out 3: current state encoding.
- `retry_cnt` out 2: retries used in the current bring-up.

## Operation
- Every asynchronous status input passes through a 2-flop synchronizer. All outputs are registered and decoded from the state register.
- State encodings:
  - IDLE=0: `hpio_rst`=1, `source_rst`=1. `start` → RST_HOLD.
  - RST_HOLD=1: `hpio_rst`=1. Timer runs for `RST_CYCLES`, then → WAIT_LOCK.
  - WAIT_LOCK=2: `hpio_rst`=0. Synchronized lock → WAIT_SEQ.
  - WAIT_SEQ=3: synchronized `rst_seq_done` AND `dly_rdy` → WAIT_VTC.
  - WAIT_VTC=4: `en_vtc`=1. Synchronized `vtc_rdy` → SETTLE.
  - SETTLE=5: `en_vtc`=1. Timer runs for `SETTLE_CYCLES`, then → RUN.
  - RUN=6: `en_vtc`=1, `source_rst`=0, `link_up`=1.
  - FAIL=7: `hpio_rst`=1, `source_rst`=1, `fail`=1.
- The timer clears on every state entry.
- Timeout: timer reaches `TIMEOUT_CYCLES` in any of states 2–4.
  - If `retry_cnt` < `MAX_RETRY`: `retry_cnt` increments, → RST_HOLD.
  - Otherwise → FAIL.
- `retry_cnt` saturates at `MAX_RETRY` and clears when `start` is accepted.
- `start` is accepted in IDLE, RUN and FAIL; it is ignored in states 1–5.
- Lock deasserts in states 3–5: immediate retry path, same rule as a timeout.
- If a ready condition and timeout occur in the same cycle, the ready condition wins.
- `rst_n` asserted at any time: all outputs and counters return to reset values immediately.

## Timing
- Reset values:
  - `hpio_rst`=1, `en_vtc`=0, `source_rst`=1.
  - `link_up`=0, `fail`=0, `state`=0, `retry_cnt`=0.
- `start` sampled at edge N: `state`=1 after edge N, `hpio_rst` stays 1.
- `hpio_rst` falls `RST_CYCLES` edges after entry to RST_HOLD.
- Input edge → state transition: 3 edges (2 synchronizer stages plus 1 state register).
- `source_rst` falls exactly `SETTLE_CYCLES`+1 edges after entry to SETTLE, in the same cycle `link_up` rises.
- `en_vtc` rises on entry to WAIT_VTC and is held through RUN.
- `en_vtc` drops to 0 on any exit to states 0, 1 or 7.

## Configuration
- `HPIO_CTRL_LOCK_MONITOR_EN` defined:
  - In RUN, loss of synchronized lock forces `source_rst`=1 and `link_up`=0 next cycle.
  - The FSM then → RST_HOLD under the retry rule; if retries are exhausted it → FAIL.
- Undefined: RUN is left only by `start` or `rst_n`, and lock is ignored in RUN.

## Test plan
- Nominal path, with `RST_CYCLES`=16, `SETTLE_CYCLES`=13:
  - Stimulus: `start`; lock 10 cycles after `hpio_rst` falls; `rst_seq_done`/`dly_rdy` 20 cycles later; `vtc_rdy` 5 cycles later.
  - Required: states 1→2→3→4→5→6; `source_rst` falls 14 edges after SETTLE entry; `retry_cnt`=0.
- Single timeout, with `TIMEOUT_CYCLES`=64:
  - Stimulus: `vtc_rdy` held low on the first attempt, then raised on the second.
  - Required: `retry_cnt`=1; `hpio_rst` is reasserted for 16 cycles; RUN is reached.
- Exhaustion:
  - Stimulus: lock never asserted, `MAX_RETRY`=3.
  - Required: four 64-cycle timeouts; then `fail`=1, `state`=7, `hpio_rst`=1. A following `start` clears `retry_cnt` and enters state 1.
- Mid-sequence reset:
  - Stimulus: `rst_n` pulsed low during WAIT_VTC.
  - Required: `en_vtc`=0 and `state`=0 asynchronously; `start` is required to resume.
- Ignored `start` and tie-break:
  - Stimulus: `start` during WAIT_SEQ; separately, `dly_rdy` arriving on the timeout cycle.
  - Required: the `start` has no effect; the tie-break advances to WAIT_VTC with no retry.
- With `HPIO_CTRL_LOCK_MONITOR_EN` defined:
  - Stimulus: lock dropped in RUN.
  - Required: `source_rst`=1 and `link_up`=0 within 4 edges, then state 1.
- Without `HPIO_CTRL_LOCK_MONITOR_EN`:
  - Stimulus: lock dropped in RUN.
  - Required: state stays 6.
